sync_fifo_param: RTL



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/fifo_ram.sv | 38 +++
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised FIFO family.
package fifo_pkg;

   // Extra pointer bit that distinguishes full from empty when addresses match.
   localparam int unsigned PTR_EXTRA_W = 1;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2_f(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing bundle of the single-clock FIFO.
interface sync_fifo_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 4
);

   logic              clear;
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   // User side: drives requests, observes data and status.
   modport master (
      output clear, wr_en, data_in, rd_en,
      input  data_out, data_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   // FIFO side.
   modport slave (
      input  clear, wr_en, data_in, rd_en,
      output data_out, data_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module fifo_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Storage array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read register holds its value between accepted reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags, sticky errors and flush.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input logic              clk,
   input logic              reset_n,
   sync_fifo_param_if.slave bus
);

   localparam int unsigned ADDR_W = clog2_f(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + PTR_EXTRA_W;

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
   end
   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             data_valid_q, data_valid_d;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             wr_accept;
   logic             rd_accept;

   // Wrap-bit pointers make the plain difference the true occupancy.
   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

   // Flush suppresses both ports so nothing is stored or read in that cycle.
   assign wr_accept = bus.wr_en && !full && !bus.clear;
   assign rd_accept = bus.rd_en && !empty && !bus.clear;

   // Next-state for pointers, sticky errors and the read-valid pulse.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      data_valid_d = 1'b0;
      if (bus.clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE_CNT;
         end
         if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE_CNT;
         end
         if (bus.wr_en && full) begin
            overflow_d = 1'b1;
         end
         if (bus.rd_en && empty) begin
            underflow_d = 1'b1;
         end
         data_valid_d = rd_accept;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         data_valid_q <= data_valid_d;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (bus.data_in),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (bus.data_out)
   );

   assign bus.data_valid   = data_valid_q;
   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AF_CNT);
   assign bus.almost_empty = (count <= AE_CNT);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule
